// File: rtl/fetch_branch_ctrl.sv
// ============================================================================
// Module      : fetch_branch_ctrl
// Description : Instruction fetch and next-PC controller. It fetches at the
//               current PC, decodes jump/branch opcodes and pulses the PC
//               select/load command on downstream accept.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_branch_ctrl #(
    parameter logic [3:0] JMP_OP = 4'hE,
    parameter logic [3:0] BR_OP  = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] pc,
    input  logic [3:0]  status,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [1:0]  ps,
    output logic [31:0] pc_in
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_ISSUE  = 2'd3
    } state_t;

    localparam logic [1:0] c_PS_HOLD = 2'b00;
    localparam logic [1:0] c_PS_INC  = 2'b01;
    localparam logic [1:0] c_PS_LOAD = 2'b10;
    localparam logic [1:0] c_PS_REL  = 2'b11;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_instr;
    logic [1:0]  r_next_ps;
    logic [31:0] r_pc_in;
    logic [1:0]  w_next_ps;
    logic [31:0] w_pc_in;
    logic        w_taken;
    logic        w_accept;

    wire w_z = status[0];
    wire w_n = status[1];
    wire w_c = status[2];
    wire w_v = status[3];

    // Branch condition evaluated against the flags present during DECODE only
    always_comb begin
        w_taken = 1'b0;
        case (r_instr[27:24])
            4'd0:    w_taken = 1'b1;
            4'd1:    w_taken = w_z;
            4'd2:    w_taken = ~w_z;
            4'd3:    w_taken = w_n;
            4'd4:    w_taken = ~w_n;
            4'd5:    w_taken = w_c;
            4'd6:    w_taken = w_v;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_ps = c_PS_INC;
        w_pc_in   = 32'd0;
        if (r_instr[31:28] == JMP_OP) begin
            w_next_ps = c_PS_LOAD;
            w_pc_in   = {4'b0000, r_instr[27:0]};
        end else if (r_instr[31:28] == BR_OP && w_taken) begin
            w_next_ps = c_PS_REL;
            w_pc_in   = {{8{r_instr[23]}}, r_instr[23:0]};
        end
    end

    assign w_accept = (r_state == S_ISSUE) && instr_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (run) w_state_next = S_FETCH;
            S_FETCH:  if (imem_ack) w_state_next = S_DECODE;
            S_DECODE: w_state_next = S_ISSUE;
            S_ISSUE:  if (instr_ready) w_state_next = run ? S_FETCH : S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_instr   <= 32'd0;
            r_next_ps <= c_PS_HOLD;
            r_pc_in   <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_FETCH && imem_ack) begin
                r_instr <= imem_rdata;
            end
            if (r_state == S_DECODE) begin
                r_next_ps <= w_next_ps;
                r_pc_in   <= w_pc_in;
            end
        end
    end

    // The address follows pc directly so a fetch right after accept sees the updated PC
    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = 32'd0;
        instr_valid = 1'b0;
        ps          = c_PS_HOLD;
        if (r_state == S_FETCH) begin
            imem_req  = 1'b1;
            imem_addr = pc;
        end
        if (r_state == S_ISSUE) begin
            instr_valid = 1'b1;
        end
        if (w_accept) begin
            ps = r_next_ps;
        end
    end

    assign instr_out = r_instr;
    assign pc_in     = r_pc_in;

endmodule

`default_nettype wire

// File: tb/tb_fetch_branch_ctrl.sv
// ============================================================================
// Module      : tb_fetch_branch_ctrl
// Description : Scoreboard bench for fetch_branch_ctrl with a transaction
//               level reference model, random stalls and a reset scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_branch_ctrl;

    localparam int c_NDIR  = 8;
    localparam int c_NRAND = 250;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] pc;
    logic [3:0]  status;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  ps;
    logic [31:0] pc_in;

    fetch_branch_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .pc          (pc),
        .status      (status),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ps          (ps),
        .pc_in       (pc_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  st;
        int          ack_dly;
        int          rdy_dly;
        bit          drop;
    } item_t;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  ps;
        logic [31:0] pc_in;
        int          lat;
    } exp_t;

    item_t       items[$];
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_issued = 0;
    logic [31:0] pc_model = 32'h10;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_req"},   32'(imem_req),    32'd0);
        chk({name, "_addr"},  imem_addr,        32'd0);
        chk({name, "_out"},   instr_out,        32'd0);
        chk({name, "_valid"}, 32'(instr_valid), 32'd0);
        chk({name, "_ps"},    32'(ps),          32'd0);
        chk({name, "_pcin"},  pc_in,            32'd0);
    endtask

    // Reference: what the program counter is told to do for one instruction
    function automatic exp_t model(input logic [31:0] w, input logic [3:0] st, input int rdy_dly);
        exp_t               e;
        bit                 taken;
        logic signed [31:0] off;
        e.word  = w;
        e.ps    = 2'b01;
        e.pc_in = 32'd0;
        e.lat   = 2 + rdy_dly;
        taken   = 1'b0;
        if (w[31:28] == 4'hE) begin
            e.ps    = 2'b10;
            e.pc_in = w & 32'h0FFF_FFFF;
        end else if (w[31:28] == 4'hF) begin
            case (w[27:24])
                4'd0:    taken = 1'b1;
                4'd1:    taken = st[0];
                4'd2:    taken = !st[0];
                4'd3:    taken = st[1];
                4'd4:    taken = !st[1];
                4'd5:    taken = st[2];
                4'd6:    taken = st[3];
                default: taken = 1'b0;
            endcase
            if (taken) begin
                off     = {w[23:0], 8'h00};
                off     = off >>> 8;
                e.ps    = 2'b11;
                e.pc_in = off;
            end
        end
        return e;
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard
    int          mcyc = 0;
    int          ack_cyc = 0;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    bit          after = 1'b0;
    bit          after_run = 1'b0;

    always @(negedge clock) begin
        if (mon_en && !reset) begin
            exp_t e;
            mcyc++;
            if (imem_req && imem_ack) begin
                chk("fetch_addr", imem_addr, pc_model);
                ack_cyc = mcyc;
            end
            if (prev_req && !prev_ack && imem_req) chk("addr_stable", imem_addr, prev_addr);
            chk("req_excl", 32'(imem_req && instr_valid), 32'd0);
            if (after) begin
                chk("after_req",   32'(imem_req),    32'(after_run));
                chk("after_valid", 32'(instr_valid), 32'd0);
                after = 1'b0;
            end
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_empty: got accept expected none");
                end else begin
                    e = sb.pop_front();
                    chk("instr_out", instr_out, e.word);
                    chk("ps",        32'(ps),   32'(e.ps));
                    chk("pc_in",     pc_in,     e.pc_in);
                    chk("latency",   32'(mcyc - ack_cyc), 32'(e.lat));
                    case (e.ps)
                        2'b01:   pc_model = pc_model + 32'd1;
                        2'b10:   pc_model = e.pc_in;
                        2'b11:   pc_model = pc_model + e.pc_in;
                        default: pc_model = pc_model;
                    endcase
                end
                n_issued++;
                after     = 1'b1;
                after_run = run;
            end else begin
                chk("ps_idle", 32'(ps), 32'd0);
            end
            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
        end
    end

    // Stimulus: memory responder, downstream ready, run and status drivers
    initial begin
        int          idx;
        int          ack_wait;
        int          rdy_wait;
        int          drop_cnt;
        bit          hold_st;
        bit          cur_drop;
        logic [3:0]  held_st;
        logic [31:0] w;
        bit          got_req;
        item_t       it;

        items.push_back('{32'h1234_5678, 4'h0, 0, 0, 1'b0});
        items.push_back('{32'hE000_0040, 4'h0, 0, 0, 1'b0});
        items.push_back('{32'hF1FF_FFFC, 4'h1, 0, 0, 1'b0});
        items.push_back('{32'hF1FF_FFFC, 4'h0, 0, 0, 1'b0});
        items.push_back('{32'hF700_0004, 4'hF, 0, 0, 1'b0});
        items.push_back('{32'h0000_0001, 4'h5, 4, 5, 1'b0});
        items.push_back('{32'hF200_0010, 4'h0, 0, 0, 1'b1});
        items.push_back('{32'hE000_0100, 4'hA, 1, 2, 1'b0});
        for (int i = 0; i < c_NRAND; i++) begin
            case ($urandom_range(0, 3))
                0:       w = {4'hE, 28'($urandom)};
                1, 2:    w = {4'hF, 4'($urandom_range(0, 8)), 24'($urandom)};
                default: w = $urandom;
            endcase
            it = '{w, 4'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                   bit'($urandom_range(0, 7) == 0)};
            items.push_back(it);
        end

        reset = 1'b1; run = 1'b0; pc = 32'h10; status = 4'h0;
        imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_outputs("reset");
        mon_en = 1'b1;
        reset  = 1'b0;
        run    = 1'b1;

        idx = 0; ack_wait = items[0].ack_dly; rdy_wait = 0; drop_cnt = 0;
        hold_st = 1'b0; cur_drop = 1'b0; held_st = 4'h0;
        for (int cyc = 0; cyc < 20000 && n_issued < items.size(); cyc++) begin
            @(posedge clock);
            #1;
            pc = pc_model;
            if (hold_st) begin
                status  = held_st;
                hold_st = 1'b0;
                if (cur_drop) drop_cnt = 12;
            end else begin
                status = 4'($urandom);
            end
            if (drop_cnt > 0) begin
                run = 1'b0;
                drop_cnt--;
            end else if (idx < c_NDIR) begin
                run = 1'b1;
            end else begin
                run = ($urandom_range(0, 9) != 0);
            end
            if (imem_req) begin
                if (ack_wait == 0 && idx < items.size()) begin
                    imem_ack   = 1'b1;
                    imem_rdata = items[idx].word;
                    held_st    = items[idx].st;
                    hold_st    = 1'b1;
                    cur_drop   = items[idx].drop;
                    rdy_wait   = items[idx].rdy_dly;
                    sb.push_back(model(items[idx].word, items[idx].st, items[idx].rdy_dly));
                    idx++;
                    if (idx < items.size()) ack_wait = items[idx].ack_dly;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    if (ack_wait > 0) ack_wait--;
                end
            end else begin
                imem_ack   = ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom;
            end
            if (instr_valid) begin
                if (rdy_wait == 0) begin
                    instr_ready = 1'b1;
                end else begin
                    instr_ready = 1'b0;
                    rdy_wait--;
                end
            end else begin
                instr_ready = 1'($urandom_range(0, 1));
            end
        end
        chk("issued_all", 32'(n_issued), 32'(items.size()));
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of a fetch; the late ack must be ignored
        run = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
        got_req = 1'b0;
        for (int k = 0; k < 50 && !got_req; k++) begin
            @(posedge clock);
            #1;
            got_req = imem_req;
        end
        chk("rst_fetch_seen", 32'(got_req), 32'd1);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        @(posedge clock);
        #1;
        reset = 1'b0;
        run   = 1'b0;
        @(posedge clock);
        #1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hE000_0040;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk_reset_outputs("rst_after");
        end
        imem_ack = 1'b0;
        pc       = 32'h0000_0200;
        run      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("resume_req",  32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr,     32'h0000_0200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_branch_ctrl.md
Name: fetch_branch_ctrl

Overview:
Instruction-fetch and next-PC controller that drives the program counter's select/load interface. It takes the current PC value, fetches the instruction at that address over a req/ack memory handshake, and decodes jump/branch opcodes. It then issues a one-cycle PS/PC_IN command to the program counter when the instruction is handed to the downstream stage. The block sits between the program counter, instruction memory and the decode/execute stage.

Parameters:
JMP_OP, 4'hE, opcode in instr[31:28] meaning absolute jump
BR_OP, 4'hF, opcode in instr[31:28] meaning conditional PC-relative branch

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  fetch enable; sampled in IDLE and at ISSUE accept
pc  input  32  current program counter value
status  input  4  flags: [0]=Z, [1]=N, [2]=C, [3]=V
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch address
imem_ack  input  1  memory response valid; imem_rdata valid in the same cycle
imem_rdata  input  32  fetched instruction word
instr_out  output  32  instruction presented downstream
instr_valid  output  1  instr_out valid
instr_ready  input  1  downstream accepts instr_out
ps  output  2  PC select: 00 hold, 01 +1, 10 load pc_in, 11 pc + pc_in
pc_in  output  32  PC load value or relative offset

Behaviour:
- Reset (asynchronous): state=IDLE, imem_req=0, imem_addr=0, instr_out=0, instr_valid=0, ps=00, pc_in=0.
- FSM states: IDLE, FETCH, DECODE, ISSUE.
- IDLE: outputs inactive, ps=00. If run=1 at the clock edge, go to FETCH.
- FETCH: imem_req=1 and imem_addr=pc, both held stable until ack. When imem_ack=1 (same cycle as req is legal), latch imem_rdata and go to DECODE. imem_ack in any other state is ignored.
- DECODE (exactly 1 cycle): sample status and compute next_ps/pc_in from the latched word:
  - instr[31:28]==JMP_OP: next_ps=10, pc_in={4'b0, instr[27:0]}.
  - instr[31:28]==BR_OP: cond=instr[27:24], offset=sign-extend(instr[23:0]) to 32 bits.
  - cond values: 0 always; 1 Z; 2 !Z; 3 N; 4 !N; 5 C; 6 V; 7–15 never.
  - Branch taken: next_ps=11, pc_in=offset. Branch not taken: next_ps=01, pc_in=0.
  - Any other opcode: next_ps=01, pc_in=0.
  - At the end of DECODE, go to ISSUE.
- ISSUE: instr_valid=1, instr_out=latched word, both stable until accepted.
  - ps = next_ps combinationally only in the cycle where instr_valid && instr_ready; ps=00 in every other cycle.
  - The program counter therefore updates exactly once per instruction, on the accept edge.
  - On accept: instr_valid drops next cycle. Go to FETCH if run=1, else IDLE.
- pc_in holds its DECODE value until the next DECODE.
- Throughput: minimum 3 cycles per instruction (FETCH with same-cycle ack, DECODE, ISSUE with ready=1).
- The block has at most one outstanding memory request. imem_req is never asserted outside FETCH.
- run deasserted mid-instruction: the current instruction completes through ISSUE (including its ps pulse), then the FSM goes to IDLE.
- Backpressure: instr_ready=0 holds ISSUE indefinitely with ps=00. No new fetch is issued.
- Status changes after DECODE do not alter the decision.
- Reset asserted in any state: immediate return to reset values. A pending memory request is abandoned and its late ack is ignored.
- The offset add and its wrap-around are performed by the program counter (mod 2^32); this block only sign-extends.

Test Plan:
- Sequential: reset, run=1, pc=0x10, ack on first FETCH cycle, rdata=0x12345678, ready=1 -> imem_addr=0x10; instr_out=0x12345678 on cycle 3; ps=01 for exactly 1 cycle; pc_in=0; next FETCH uses the new pc.
- Jump: rdata=0xE0000040 -> ps=10, pc_in=0x00000040 in the accept cycle only.
- Branch: Z=1, rdata=0xF1FFFFFC -> ps=11, pc_in=0xFFFFFFFC. Repeat with Z=0 -> ps=01, pc_in=0. Repeat with cond=7 (0xF7000004) -> ps=01.
- Stalls: ack delayed 4 cycles and ready held low 5 cycles -> imem_req and addr stable throughout; instr_valid held; ps=00 until ready=1; single ps pulse; no second req.
- Run drop: run=0 during DECODE -> instruction still issued with ps pulse, then IDLE with imem_req=0; run=1 resumes fetch.
- Reset during FETCH with ack arriving the cycle after reset release -> all outputs at reset values; the ack is ignored; ps stays 00.
